// File: rtl/ad7673_pkg.sv
// rtl/ad7673_pkg.sv - shared constants and types for the AD7673 conversion interface
package ad7673_pkg;

    localparam int AD7673_DATA_WIDTH = 18;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } ad7673_state_t;

endpackage

// File: rtl/ad7673_emulator_sample_holding_reg.sv
// rtl/ad7673_emulator_sample_holding_reg.sv - one-entry valid/ready sample buffer
module sample_holding_reg
    import ad7673_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [AD7673_DATA_WIDTH-1:0] in_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         take_i,
    output logic [AD7673_DATA_WIDTH-1:0] out_o,
    output logic                         full_o
);

    logic                         full_q, full_d;
    logic [AD7673_DATA_WIDTH-1:0] data_q, data_d;

    assign ready_o = !full_q;
    assign full_o  = full_q;
    assign out_o   = data_q;

    // A take only happens while full, so it never collides with a transfer.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (take_i) begin
            full_d = 1'b0;
        end else if (valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = in_i;
        end
    end

    // Buffer state register; reset discards any held sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/ad7673_emulator.sv
// rtl/ad7673_emulator.sv - AD7673 CNVST_N/BUSY/DATA responder fed from a sample buffer
module ad7673_emulator
    import ad7673_pkg::*;
#(
    parameter int CONV_CYCLES = 40,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         CNVST_N,
    output logic                         BUSY,
    output logic [AD7673_DATA_WIDTH-1:0] AD7673_DATA,
    input  logic [AD7673_DATA_WIDTH-1:0] sample_in,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic                         clear_flags,
    output logic                         underrun,
    output logic                         overrun,
    output logic [COUNT_WIDTH-1:0]       conv_count
);

    localparam int                CNT_W    = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CONV_CYCLES - 1);

    ad7673_state_t                state_q, state_d;
    logic                         cnv_q;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         busy_q, busy_d;
    logic [AD7673_DATA_WIDTH-1:0] data_q, data_d;
    logic [AD7673_DATA_WIDTH-1:0] last_q, last_d;
    logic [AD7673_DATA_WIDTH-1:0] latch_q, latch_d;
    logic                         underrun_q, underrun_d;
    logic                         overrun_q, overrun_d;
    logic [COUNT_WIDTH-1:0]       count_q, count_d;

    logic                         start;
    logic                         take;
    logic                         buf_full;
    logic [AD7673_DATA_WIDTH-1:0] buf_out;
    logic                         underrun_set;
    logic                         overrun_set;

    sample_holding_reg u_buf (
        .clk     (clk),
        .reset   (reset),
        .in_i    (sample_in),
        .valid_i (sample_valid),
        .ready_o (sample_ready),
        .take_i  (take),
        .out_o   (buf_out),
        .full_o  (buf_full)
    );

    assign start       = cnv_q && !CNVST_N;
    assign BUSY        = busy_q;
    assign AD7673_DATA = data_q;
    assign underrun    = underrun_q;
    assign overrun     = overrun_q;
    assign conv_count  = count_q;

    // Conversion FSM: latch on a falling edge, publish the result as BUSY drops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        data_d       = data_q;
        last_d       = last_q;
        latch_d      = latch_q;
        count_d      = count_q;
        take         = 1'b0;
        underrun_set = 1'b0;
        overrun_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // An empty buffer repeats the previous sample rather than
                    // bypassing a sample arriving in this same cycle.
                    take         = buf_full;
                    underrun_set = !buf_full;
                    latch_d      = buf_full ? buf_out : last_q;
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = CONVERT;
                end
            end
            CONVERT: begin
                overrun_set = start;
                if (cnt_q == CNT_LAST) begin
                    data_d  = latch_q;
                    last_d  = latch_q;
                    busy_d  = 1'b0;
                    count_d = count_q + COUNT_WIDTH'(1);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        underrun_d = (underrun_q && !clear_flags) || underrun_set;
        overrun_d  = (overrun_q && !clear_flags) || overrun_set;
    end

    // State registers; reset aborts any conversion in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnv_q      <= 1'b1;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            data_q     <= '0;
            last_q     <= '0;
            latch_q    <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnv_q      <= CNVST_N;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
            last_q     <= last_d;
            latch_q    <= latch_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_ad7673_emulator.sv
// tb/tb_ad7673_emulator.sv - self-checking bench for ad7673_emulator
module tb_ad7673_emulator;

    localparam int CONV = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        CNVST_N;
    logic        BUSY;
    logic [17:0] AD7673_DATA;
    logic [17:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        clear_flags;
    logic        underrun;
    logic        overrun;
    logic [15:0] conv_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: buffer queue, last converted sample, flags, count.
    logic [17:0] mq[$];
    logic [17:0] last_m;
    logic        under_m;
    logic        over_m;
    int          count_m;

    always #5 clk = ~clk;

    ad7673_emulator #(.CONV_CYCLES(CONV), .COUNT_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .CNVST_N      (CNVST_N),
        .BUSY         (BUSY),
        .AD7673_DATA  (AD7673_DATA),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .clear_flags  (clear_flags),
        .underrun     (underrun),
        .overrun      (overrun),
        .conv_count   (conv_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        CNVST_N      = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        clear_flags  = 1'b0;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        mq.delete();
        last_m  = '0;
        under_m = 1'b0;
        over_m  = 1'b0;
        count_m = 0;
    endtask

    task automatic push(input logic [17:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        mq.push_back(v);
        chk("push_ready_low", 32'(sample_ready), 32'd0);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        under_m = 1'b0;
        over_m  = 1'b0;
    endtask

    // One conversion from a 1-cycle CNVST_N pulse; glitch_at>=2 adds a second
    // falling edge that many cycles into BUSY.
    task automatic conv(input string tag, input int glitch_at);
        logic [17:0] exp;
        logic [17:0] prev;
        int          hi;
        bit          stable;
        if (mq.size() > 0) exp = mq.pop_front();
        else begin
            exp     = last_m;
            under_m = 1'b1;
        end
        prev    = AD7673_DATA;
        stable  = 1'b1;
        CNVST_N = 1'b0;
        tick();
        CNVST_N = 1'b1;
        hi = 0;
        while (BUSY === 1'b1 && hi < 200) begin
            hi++;
            if (AD7673_DATA !== prev) stable = 1'b0;
            CNVST_N = (hi == glitch_at) ? 1'b0 : 1'b1;
            tick();
        end
        CNVST_N = 1'b1;
        if (glitch_at >= 2 && glitch_at < CONV) over_m = 1'b1;
        last_m = exp;
        count_m++;
        chk({tag, "_busy_len"}, 32'(hi), 32'(CONV));
        chk({tag, "_data_held"}, 32'(stable), 32'd1);
        chk({tag, "_data"}, 32'(AD7673_DATA), 32'(exp));
        chk({tag, "_count"}, 32'(conv_count), 32'(count_m % 65536));
        chk({tag, "_underrun"}, 32'(underrun), 32'(under_m));
        chk({tag, "_overrun"}, 32'(overrun), 32'(over_m));
    endtask

    initial begin
        int          n;
        int          hi;
        logic [17:0] s;

        // 1: reset state, then a single buffered conversion
        reset_dut();
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_data", 32'(AD7673_DATA), 32'd0);
        chk("rst_ready", 32'(sample_ready), 32'd1);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_count", 32'(conv_count), 32'd0);
        push(18'h1ABCD);
        conv("t1", 0);

        // 2: two conversions with an empty buffer, then clear_flags
        reset_dut();
        conv("t2a", 0);
        conv("t2b", 0);
        pulse_clear();
        chk("t2_cleared", 32'(underrun), 32'd0);

        // 3: second falling edge mid-conversion
        reset_dut();
        push(18'h2_5A5A);
        conv("t3", 10);

        // 4: held valid while full, consumed by a start, then accepted
        reset_dut();
        push(18'h00001);
        sample_in    = 18'h00002;
        sample_valid = 1'b1;
        tick();
        tick();
        chk("t4_ready_while_full", 32'(sample_ready), 32'd0);
        conv("t4a", 0);
        mq.push_back(18'h00002);
        chk("t4_refilled", 32'(sample_ready), 32'd0);
        sample_valid = 1'b0;
        conv("t4b", 0);

        // 5: reset 20 cycles into a conversion with a sample buffered
        reset_dut();
        push(18'h2_0F0F);
        CNVST_N = 1'b0;
        tick();
        CNVST_N      = 1'b1;
        sample_in    = 18'h1_1111;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (18) tick();
        reset_dut();
        chk("t5_busy", 32'(BUSY), 32'd0);
        chk("t5_data", 32'(AD7673_DATA), 32'd0);
        chk("t5_count", 32'(conv_count), 32'd0);
        chk("t5_ready", 32'(sample_ready), 32'd1);
        conv("t5_after", 0);

        // 6: start exactly as BUSY falls, CNVST_N then held low 100 cycles
        reset_dut();
        s = 18'h3_C3C3;
        push(s);
        CNVST_N = 1'b0;
        tick();
        CNVST_N = 1'b1;
        n = 0;
        while (BUSY === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk("t6_first_len", 32'(n), 32'(CONV));
        CNVST_N = 1'b0;
        hi = 0;
        repeat (100) begin
            tick();
            if (BUSY === 1'b1) hi++;
        end
        CNVST_N = 1'b1;
        tick();
        chk("t6_second_len", 32'(hi), 32'(CONV));
        chk("t6_count", 32'(conv_count), 32'd2);
        chk("t6_overrun", 32'(overrun), 32'd0);
        chk("t6_data", 32'(AD7673_DATA), 32'(s));
        chk("t6_underrun", 32'(underrun), 32'd1);

        // Randomized mix of pushes, flag clears, and overlapping starts
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) push(18'($urandom));
            chk("rnd_ready", 32'(sample_ready), 32'(mq.size() == 0));
            if ($urandom_range(0, 3) == 0) pulse_clear();
            conv("rnd", ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, CONV - 1)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
